// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: geometry, address-split widths, counter width and the
// sequencer state encoding shared by the sequencer, cache stage and memory model.
package cache_sim_pkg;

  localparam int ADDR_BITS              = 32;
  localparam int WAY                    = 16;
  localparam int BLOCK_SIZE_BYTE        = 4;
  localparam int CACHE_SIZE_BYTE        = 65536;
  localparam int LOOKUP_TIMEOUT_DEFAULT = 64;

  // Derived geometry; these are not meant to be overridden independently.
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_BYTE);
  localparam int SET         = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
  localparam int INDEX_BITS  = $clog2(SET);
  localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int BLOCK_BITS  = 8 * BLOCK_SIZE_BYTE;

  localparam int CNT_BITS = 16;
  typedef logic [CNT_BITS-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOOKUP      = 3'd1,
    ST_WAIT_LOOKUP = 3'd2,
    ST_MEM_REQ     = 3'd3,
    ST_FILL        = 3'd4
  } seq_state_t;

  // Statistics counters wrap silently at 2^CNT_BITS.
  function automatic count_t count_inc(input count_t value);
    return value + {{(CNT_BITS-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/cache_request_sequencer_if.sv
// cache_request_sequencer_if: trace handshake, lookup launch/verdict, block
// fetch, fill strobe and statistics between the sequencer and its neighbours.
interface cache_request_sequencer_if;
  import cache_sim_pkg::*;

  logic                   addr_valid;
  logic [ADDR_BITS-1:0]   addr;
  logic                   addr_ready;
  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] block_offset;
  logic                   lookup_start;
  logic                   lookup_done;
  logic                   lookup_hit;
  logic                   mem_req;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic                   mem_valid;
  logic [BLOCK_BITS-1:0]  mem_data;
  logic [BLOCK_BITS-1:0]  block;
  logic                   control;
  logic                   updated;
  logic                   busy;
  logic [CNT_BITS-1:0]    req_count;
  logic [CNT_BITS-1:0]    hit_count;
  logic [CNT_BITS-1:0]    miss_count;
  logic                   timeout_err;

  // Sequencer side.
  modport master (
    input  addr_valid, addr, lookup_done, lookup_hit, mem_valid, mem_data, updated,
    output addr_ready, tag, index, block_offset, lookup_start, mem_req, mem_addr,
           block, control, busy, req_count, hit_count, miss_count, timeout_err
  );

  // Trace source, cache stage and memory model side.
  modport slave (
    output addr_valid, addr, lookup_done, lookup_hit, mem_valid, mem_data, updated,
    input  addr_ready, tag, index, block_offset, lookup_start, mem_req, mem_addr,
           block, control, busy, req_count, hit_count, miss_count, timeout_err
  );

endinterface

// File: rtl/cache_request_sequencer_addr_splitter.sv
// addr_splitter: combinational byte address -> {tag, index, offset, block-aligned
// address}. Shared with the memory model so both agree on the split.
module addr_splitter
  import cache_sim_pkg::*;
(
  input  logic [ADDR_BITS-1:0]   addr,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] block_offset,
  output logic [ADDR_BITS-1:0]   aligned_addr
);

  assign tag          = addr[ADDR_BITS-1 -: TAG_BITS];
  assign index        = addr[OFFSET_BITS +: INDEX_BITS];
  assign block_offset = addr[OFFSET_BITS-1:0];
  assign aligned_addr = {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

endmodule

// File: rtl/cache_request_sequencer.sv
// cache_request_sequencer: accepts trace addresses, launches a cache lookup,
// fetches and fills the block on a miss, and keeps request/hit/miss statistics.
module cache_request_sequencer
  import cache_sim_pkg::*;
#(
  parameter int LOOKUP_TIMEOUT = LOOKUP_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  cache_request_sequencer_if.master    bus
);

  localparam int TO_W = (LOOKUP_TIMEOUT > 1) ? $clog2(LOOKUP_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOOKUP_TIMEOUT - 1);

  seq_state_t             state_r;
  seq_state_t             next_s;
  logic                   capture_s;
  logic                   hit_s;
  logic                   miss_s;
  logic                   timeout_s;
  logic                   fill_load_s;

  logic [ADDR_BITS-1:0]   addr_r;
  logic [BLOCK_BITS-1:0]  block_r;
  logic [TO_W-1:0]        to_cnt_r;
  count_t                 req_count_r;
  count_t                 hit_count_r;
  count_t                 miss_count_r;
  logic                   timeout_err_r;
  logic                   addr_ready_r;
  logic                   lookup_start_r;
  logic                   mem_req_r;
  logic                   control_r;
  logic                   busy_r;

  logic [TAG_BITS-1:0]    tag_s;
  logic [INDEX_BITS-1:0]  index_s;
  logic [OFFSET_BITS-1:0] offset_s;
  logic [ADDR_BITS-1:0]   aligned_s;

  // Fields come from the captured address, so they hold still for the whole request.
  addr_splitter u_addr_splitter (
    .addr         (addr_r),
    .tag          (tag_s),
    .index        (index_s),
    .block_offset (offset_s),
    .aligned_addr (aligned_s)
  );

  // Next-state decode; lookup_done is only honoured while waiting for it.
  always_comb begin
    next_s      = state_r;
    capture_s   = 1'b0;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    timeout_s   = 1'b0;
    fill_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.addr_valid && addr_ready_r) begin
          next_s    = ST_LOOKUP;
          capture_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        next_s = ST_WAIT_LOOKUP;
      end
      ST_WAIT_LOOKUP: begin
        if (bus.lookup_done) begin
          if (bus.lookup_hit) begin
            hit_s  = 1'b1;
            next_s = ST_IDLE;
          end else begin
            next_s = ST_MEM_REQ;
          end
        end else if (to_cnt_r == TO_LAST) begin
          // No verdict in time: flag it and fetch the block as if it missed.
          timeout_s = 1'b1;
          next_s    = ST_MEM_REQ;
        end else begin
          next_s = ST_WAIT_LOOKUP;
        end
      end
      ST_MEM_REQ: begin
        if (bus.mem_valid) begin
          fill_load_s = 1'b1;
          next_s      = ST_FILL;
        end else begin
          next_s = ST_MEM_REQ;
        end
      end
      ST_FILL: begin
        if (bus.updated) begin
          miss_s = 1'b1;
          next_s = ST_IDLE;
        end else begin
          next_s = ST_FILL;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Registered control outputs decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_ready_r   <= 1'b0;
      lookup_start_r <= 1'b0;
      mem_req_r      <= 1'b0;
      control_r      <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      addr_ready_r   <= (next_s == ST_IDLE);
      lookup_start_r <= (next_s == ST_LOOKUP);
      mem_req_r      <= (next_s == ST_MEM_REQ);
      control_r      <= (next_s == ST_FILL);
      busy_r         <= (next_s != ST_IDLE);
    end
  end

  // Captured address and fetched block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= {ADDR_BITS{1'b0}};
      block_r <= {BLOCK_BITS{1'b0}};
    end else begin
      if (capture_s) begin
        addr_r <= bus.addr;
      end
      if (fill_load_s) begin
        block_r <= bus.mem_data;
      end
    end
  end

  // Lookup timeout counter: restarts with each launch, runs while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_LOOKUP) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_WAIT_LOOKUP) begin
      to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Statistics and the sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_count_r   <= {CNT_BITS{1'b0}};
      hit_count_r   <= {CNT_BITS{1'b0}};
      miss_count_r  <= {CNT_BITS{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (capture_s) begin
        req_count_r <= count_inc(req_count_r);
      end
      if (hit_s) begin
        hit_count_r <= count_inc(hit_count_r);
      end
      if (miss_s) begin
        miss_count_r <= count_inc(miss_count_r);
      end
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign bus.addr_ready   = addr_ready_r;
  assign bus.tag          = tag_s;
  assign bus.index        = index_s;
  assign bus.block_offset = offset_s;
  assign bus.mem_addr     = aligned_s;
  assign bus.lookup_start = lookup_start_r;
  assign bus.mem_req      = mem_req_r;
  assign bus.block        = block_r;
  assign bus.control      = control_r;
  assign bus.busy         = busy_r;
  assign bus.req_count    = req_count_r;
  assign bus.hit_count    = hit_count_r;
  assign bus.miss_count   = miss_count_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_cache_request_sequencer.sv
// tb_cache_request_sequencer: table of requests driven through a cache-stage /
// memory responder, expected fields held in a scoreboard queue, plus
// hand-written sequences for timing corners, counter wrap and mid-flight reset.
module tb_cache_request_sequencer;
  import cache_sim_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic        no_done;
    int          lk_delay;
    int          mem_delay;
    int          upd_delay;
    logic [31:0] mem_data;
    logic [19:0] exp_tag;
    logic [9:0]  exp_index;
    logic [1:0]  exp_off;
    logic [31:0] exp_mem_addr;
  } vec_t;

  typedef struct {
    logic [19:0] tag;
    logic [9:0]  index;
    logic [1:0]  off;
    logic [31:0] mem_addr;
    logic        miss;
    logic [31:0] block;
  } exp_t;

  logic clk;
  logic reset;
  cache_request_sequencer_if bus();

  cache_request_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ls_cnt = 0;
  exp_t sb[$];
  vec_t vecs[8];
  logic [15:0] m_req = 16'd0;
  logic [15:0] m_hit = 16'd0;
  logic [15:0] m_miss = 16'd0;
  logic        m_to = 1'b0;
  logic [31:0] m_block = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.lookup_start === 1'b1) ls_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag_name);
    chk({tag_name, "_req_count"}, {16'd0, bus.req_count}, {16'd0, m_req});
    chk({tag_name, "_hit_count"}, {16'd0, bus.hit_count}, {16'd0, m_hit});
    chk({tag_name, "_miss_count"}, {16'd0, bus.miss_count}, {16'd0, m_miss});
    chk({tag_name, "_timeout_err"}, {31'd0, bus.timeout_err}, {31'd0, m_to});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.addr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_addr_ready", {31'd0, bus.addr_ready}, 32'd1);
  endtask

  // One full request: handshake, lookup response, optional fetch and fill.
  task automatic run_req(input vec_t v);
    exp_t e;
    exp_t got;
    int   n;
    bit   ctl_ok;
    wait_ready();
    bus.addr       = v.addr;
    bus.addr_valid = 1'b1;
    e.tag      = v.exp_tag;
    e.index    = v.exp_index;
    e.off      = v.exp_off;
    e.mem_addr = v.exp_mem_addr;
    e.miss     = !v.hit || v.no_done;
    e.block    = v.mem_data;
    sb.push_back(e);
    m_req++;
    @(negedge clk);
    bus.addr_valid = 1'b0;
    bus.addr       = $urandom();
    chk("lookup_start_pulse", {31'd0, bus.lookup_start}, 32'd1);
    chk("addr_ready_busy", {31'd0, bus.addr_ready}, 32'd0);
    if (v.no_done) begin
      n = 0;
      @(negedge clk);
      while (bus.mem_req !== 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_wait_cycles", n, 32'd64);
      m_to = 1'b1;
    end else begin
      repeat (v.lk_delay) @(negedge clk);
      chk("lookup_start_low", {31'd0, bus.lookup_start}, 32'd0);
      bus.lookup_done = 1'b1;
      bus.lookup_hit  = v.hit;
      @(negedge clk);
      bus.lookup_done = 1'b0;
      bus.lookup_hit  = 1'($urandom_range(0, 1));
    end
    if (e.miss) begin
      ctl_ok = 1'b1;
      for (int i = 0; i < v.mem_delay; i++) begin
        if (bus.mem_req !== 1'b1) ctl_ok = 1'b0;
        @(negedge clk);
      end
      chk("mem_req_held", {31'd0, bus.mem_req & ctl_ok}, 32'd1);
      chk("mem_addr_at_req", bus.mem_addr, v.exp_mem_addr);
      bus.mem_valid = 1'b1;
      bus.mem_data  = v.mem_data;
      @(negedge clk);
      bus.mem_valid = 1'b0;
      bus.mem_data  = $urandom();
      chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
      ctl_ok = 1'b1;
      for (int i = 0; i < v.upd_delay; i++) begin
        if (bus.control !== 1'b1) ctl_ok = 1'b0;
        @(negedge clk);
      end
      chk("control_held", {31'd0, bus.control & ctl_ok}, 32'd1);
      bus.updated = 1'b1;
      @(negedge clk);
      bus.updated = 1'b0;
      chk("control_drop", {31'd0, bus.control}, 32'd0);
      m_miss++;
      m_block = v.mem_data;
    end else begin
      m_hit++;
    end
    chk("addr_ready_return", {31'd0, bus.addr_ready}, 32'd1);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("tag", {12'd0, bus.tag}, {12'd0, got.tag});
      chk("index", {22'd0, bus.index}, {22'd0, got.index});
      chk("block_offset", {30'd0, bus.block_offset}, {30'd0, got.off});
      chk("mem_addr", bus.mem_addr, got.mem_addr);
      if (got.miss) chk("block", bus.block, got.block);
    end
    chk_counters("req");
  endtask

  initial begin
    int start_ls;
    bus.addr_valid  = 1'b0;
    bus.addr        = 32'd0;
    bus.lookup_done = 1'b0;
    bus.lookup_hit  = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = 32'd0;
    bus.updated     = 1'b0;
    reset = 1'b1;

    vecs[0] = '{32'h0001_2344, 1'b1, 1'b0, 2, 0, 0, 32'h0,         20'h00012, 10'h0D1, 2'd0, 32'h0001_2344};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 3, 8, 1, 32'hCAFE_F00D, 20'hDEADB, 10'h3BB, 2'd3, 32'hDEAD_BEEC};
    vecs[2] = '{32'h1234_5677, 1'b1, 1'b0, 1, 0, 0, 32'h0,         20'h12345, 10'h19D, 2'd3, 32'h1234_5674};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1, 3, 32'h0123_4567, 20'hFFFFF, 10'h3FF, 2'd3, 32'hFFFF_FFFC};
    vecs[4] = '{32'h8000_0003, 1'b0, 1'b0, 2, 0, 0, 32'h5A5A_0F0F, 20'h80000, 10'h000, 2'd3, 32'h8000_0000};
    vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 64, 0, 0, 32'h0,        20'h00000, 10'h000, 2'd0, 32'h0000_0000};
    vecs[6] = '{32'hA5A5_5A5A, 1'b0, 1'b1, 0, 2, 1, 32'h5555_AAAA, 20'hA5A55, 10'h296, 2'd2, 32'hA5A5_5A58};
    vecs[7] = '{32'h0000_0FFC, 1'b1, 1'b0, 3, 0, 0, 32'h0,         20'h00000, 10'h3FF, 2'd0, 32'h0000_0FFC};

    // Reset state.
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr_ready", {31'd0, bus.addr_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_outputs", {29'd0, bus.lookup_start, bus.mem_req, bus.control}, 32'd0);
    chk("rst_tag_mem_addr", bus.mem_addr | {12'd0, bus.tag}, 32'd0);
    chk("rst_block", bus.block, 32'd0);
    chk_counters("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, bus.addr_ready}, 32'd1);

    // Table of requests, including the lookup_done-vs-timeout tie and a timeout.
    for (int i = 0; i < 8; i++) run_req(vecs[i]);

    // lookup_done in the LOOKUP cycle itself must be ignored.
    wait_ready();
    bus.addr = 32'h0000_2000;
    bus.addr_valid = 1'b1;
    @(negedge clk);
    bus.addr_valid  = 1'b0;
    bus.lookup_done = 1'b1;
    bus.lookup_hit  = 1'b1;
    @(negedge clk);
    bus.lookup_done = 1'b0;
    m_req++;
    chk("early_done_ignored_busy", {31'd0, bus.busy}, 32'd1);
    chk("early_done_ignored_hits", {16'd0, bus.hit_count}, {16'd0, m_hit});
    bus.lookup_done = 1'b1;
    @(negedge clk);
    bus.lookup_done = 1'b0;
    m_hit++;
    chk_counters("early_done");

    // Stray responses in IDLE change nothing.
    bus.lookup_done = 1'b1;
    bus.mem_valid   = 1'b1;
    bus.mem_data    = 32'h1111_2222;
    bus.updated     = 1'b1;
    @(negedge clk);
    bus.lookup_done = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.updated     = 1'b0;
    @(negedge clk);
    chk("stray_busy", {31'd0, bus.busy}, 32'd0);
    chk("stray_block", bus.block, m_block);
    chk_counters("stray");

    // Back-to-back hits with addr_valid held high.
    start_ls = ls_cnt;
    wait_ready();
    bus.addr_valid = 1'b1;
    bus.addr = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_tag", {12'd0, bus.tag}, i + 1);
      chk("b2b_index", {22'd0, bus.index}, i);
      if (i < 3) bus.addr = 32'h0000_1000 * (i + 2) + 32'd4 * (i + 1);
      else bus.addr_valid = 1'b0;
      @(negedge clk);
      bus.lookup_done = 1'b1;
      bus.lookup_hit  = 1'b1;
      @(negedge clk);
      bus.lookup_done = 1'b0;
    end
    m_req  = m_req + 16'd4;
    m_hit  = m_hit + 16'd4;
    chk("b2b_lookup_starts", ls_cnt - start_ls, 32'd4);
    chk_counters("b2b");

    // hit_count wrap: preload 0xFFFF, one more hit.
    force dut.hit_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count_r;
    @(negedge clk);
    chk("wrap_preload", {16'd0, bus.hit_count}, 32'h0000_FFFF);
    m_hit = 16'hFFFF;
    run_req(vecs[2]);
    chk("wrap_hit_count", {16'd0, bus.hit_count}, 32'd0);

    // Reset pulsed during FILL.
    wait_ready();
    bus.addr = 32'h0BAD_F00C;
    bus.addr_valid = 1'b1;
    @(negedge clk);
    bus.addr_valid = 1'b0;
    @(negedge clk);
    bus.lookup_done = 1'b1;
    bus.lookup_hit  = 1'b0;
    @(negedge clk);
    bus.lookup_done = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'h7777_8888;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("fill_before_reset", {31'd0, bus.control}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_outputs", {29'd0, bus.control, bus.mem_req, bus.busy}, 32'd0);
    chk("midrst_ready", {31'd0, bus.addr_ready}, 32'd0);
    chk("midrst_block", bus.block, 32'd0);
    m_req = 16'd0; m_hit = 16'd0; m_miss = 16'd0; m_to = 1'b0;
    chk_counters("midrst");
    @(negedge clk);
    reset = 1'b1;
    run_req(vecs[1]);
    run_req(vecs[0]);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
